accum_square_loop_ctrl: RTL and testbench
=========================================

ACCUM_SQUARE_LOOP_CTRL -- requirements
Module: accum_square_loop_ctrl

Interface
REQ-001 Parameter BITS, default 382, width of the operand and result words, which must equal the downstream multiplier's BITS.
REQ-002 Parameter CNT_W, default 64, width of the iteration count.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_val  input  1  job request valid.
REQ-006 o_rdy  output  1  job request ready.
REQ-007 i_dat  input  BITS  initial value x0.
REQ-008 i_t  input  CNT_W  number of modular squarings T.
REQ-009 o_mul_val  output  1  operand valid, sent to the multiplier.
REQ-010 i_mul_rdy  input  1  multiplier accepts operands.
REQ-011 o_mul_dat_a, o_mul_dat_b  output  BITS each  multiplier operands.
REQ-012 i_mul_val  input  1  multiplier result valid.
REQ-013 o_mul_rdy  output  1  controller accepts the multiplier result.
REQ-014 i_mul_dat  input  BITS  multiplier result.
REQ-015 o_val  output  1  final result valid.
REQ-016 i_rdy  input  1  downstream accepts the final result.
REQ-017 o_dat  output  BITS  final result x0^(2^T) mod MODULUS.
REQ-018 o_iter  output  CNT_W  count of completed squarings.

Function
REQ-019 The block SHALL run a four-state FSM with states IDLE, ISSUE, WAIT and DONE.
REQ-020 A handshake SHALL complete on a channel in any cycle where both valid and ready are high on that channel.
REQ-021 o_rdy SHALL be 1 only in IDLE.
REQ-022 On an IDLE job handshake, the block SHALL latch i_dat into the working register acc, latch i_t into rem, and clear o_iter.
REQ-023 On an IDLE job handshake, the next state SHALL be ISSUE if i_t!=0 and DONE if i_t==0.
REQ-024 In ISSUE, o_mul_val SHALL be 1 and o_mul_dat_a and o_mul_dat_b SHALL both equal acc.
REQ-025 In ISSUE, the FSM SHALL move to WAIT on a multiplier operand handshake and SHALL hold state and data otherwise.
REQ-026 o_mul_val SHALL be 0 in every state other than ISSUE.
REQ-027 In WAIT, o_mul_rdy SHALL be 1 and o_mul_rdy SHALL be 0 in all other states.
REQ-028 i_mul_val in any state other than WAIT SHALL be ignored and SHALL leave the state unchanged.
REQ-029 On a result handshake in WAIT, the block SHALL load acc with i_mul_dat, decrement rem, and increment o_iter.
REQ-030 On a result handshake in WAIT, the next state SHALL be DONE if the pre-decrement rem==1 and ISSUE otherwise.
REQ-031 At most one multiplier operation SHALL be outstanding at any time.
REQ-032 In DONE, o_val SHALL be 1 and o_dat SHALL equal acc, and both SHALL be held stable until i_rdy is 1.
REQ-033 The DONE-to-IDLE transition SHALL occur on the output handshake, and a new job SHALL be accepted no earlier than the following cycle.
REQ-034 The first ISSUE cycle SHALL be 1 cycle after the job handshake.
REQ-035 The next ISSUE cycle SHALL be 1 cycle after each result handshake.
REQ-036 DONE SHALL be entered 1 cycle after the final result handshake.
REQ-037 T=0 SHALL give o_val=1 one cycle after the job handshake with o_dat=x0.
REQ-038 rem and o_iter SHALL be unsigned values of width CNT_W.
REQ-039 T=2^CNT_W-1 SHALL be supported without wrap: o_iter SHALL reach 2^CNT_W-1 at DONE.
REQ-040 The controller SHALL perform no arithmetic on data other than passing values through.

Reset
REQ-041 i_rst_n=0 SHALL immediately force the FSM to IDLE, o_rdy=1, o_val=0, o_mul_val=0, o_mul_rdy=0, and acc, rem, o_iter, o_dat, o_mul_dat_a and o_mul_dat_b to 0.
REQ-042 A reset asserted in WAIT SHALL abandon the job, and any result the multiplier delivers later SHALL be ignored under REQ-028.
REQ-043 After reset is deasserted, the first job SHALL be accepted no earlier than the first rising edge with i_rst_n=1.

Verification
REQ-044 Job x0=3, T=3 against a multiplier model with MODULUS=7 and fixed latency 5 -> operands 3, 2, 4 issued, o_dat=2, o_iter=3, o_val asserted 3*(latency+2)+1 cycles after accept.
REQ-045 T=0, x0=0x55 -> o_val=1 in the cycle after accept, o_dat=0x55, o_iter=0, o_mul_val never asserted.
REQ-046 i_mul_rdy held at 0 for 10 cycles in ISSUE -> o_mul_val stays 1 with operands stable, and no state advance occurs.
REQ-047 i_rdy=0 for 8 cycles in DONE -> o_val and o_dat held stable, o_rdy=0, and an offered job is not accepted until 1 cycle after the output handshake.
REQ-048 i_rst_n pulsed low during WAIT, then the multiplier returns i_mul_val=1 -> outputs are at reset values, the result is ignored, and the next job completes correctly.
REQ-049 Random back-to-back jobs with random i_mul_rdy/i_mul_val/i_rdy stalls -> every o_dat matches a reference model and exactly T operand handshakes occur per job.

Source files
------------

// File: rtl/accum_square_loop_ctrl_if.sv
// Handshake bundle between the repeated-squaring controller, its job source,
// the external modular multiplier and the result sink.
interface accum_square_loop_ctrl_if #(
    parameter int BITS  = 382,
    parameter int CNT_W = 64
) ();
    logic             i_val;
    logic             o_rdy;
    logic [BITS-1:0]  i_dat;
    logic [CNT_W-1:0] i_t;

    logic             o_mul_val;
    logic             i_mul_rdy;
    logic [BITS-1:0]  o_mul_dat_a;
    logic [BITS-1:0]  o_mul_dat_b;
    logic             i_mul_val;
    logic             o_mul_rdy;
    logic [BITS-1:0]  i_mul_dat;

    logic             o_val;
    logic             i_rdy;
    logic [BITS-1:0]  o_dat;
    logic [CNT_W-1:0] o_iter;

    modport slave (
        input  i_val, i_dat, i_t, i_mul_rdy, i_mul_val, i_mul_dat, i_rdy,
        output o_rdy, o_mul_val, o_mul_dat_a, o_mul_dat_b, o_mul_rdy,
        output o_val, o_dat, o_iter
    );

    modport master (
        output i_val, i_dat, i_t, i_mul_rdy, i_mul_val, i_mul_dat, i_rdy,
        input  o_rdy, o_mul_val, o_mul_dat_a, o_mul_dat_b, o_mul_rdy,
        input  o_val, o_dat, o_iter
    );
endinterface

// File: rtl/accum_square_loop_ctrl.sv
// Sequencer for x0^(2^T) mod N: feeds acc to an external modular multiplier
// as both operands T times, keeping exactly one operation in flight.
module accum_square_loop_ctrl #(
    parameter int BITS  = 382,
    parameter int CNT_W = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    accum_square_loop_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [BITS-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] iter_q, iter_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        iter_d  = iter_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_val) begin
                    acc_d   = bus.i_dat;
                    rem_d   = bus.i_t;
                    iter_d  = '0;
                    state_d = (bus.i_t != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (bus.i_mul_rdy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // rem is tested before the decrement so T = 2^CNT_W-1 never wraps
                if (bus.i_mul_val) begin
                    acc_d   = bus.i_mul_dat;
                    rem_d   = rem_q - CNT_W'(1);
                    iter_d  = iter_q + CNT_W'(1);
                    state_d = (rem_q == CNT_W'(1)) ? DONE : ISSUE;
                end
            end
            DONE: begin
                if (bus.i_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_rdy       = (state_q == IDLE);
    assign bus.o_mul_val   = (state_q == ISSUE);
    assign bus.o_mul_rdy   = (state_q == WAIT);
    assign bus.o_val       = (state_q == DONE);
    assign bus.o_mul_dat_a = acc_q;
    assign bus.o_mul_dat_b = acc_q;
    assign bus.o_dat       = acc_q;
    assign bus.o_iter      = iter_q;

endmodule

// File: tb/tb_accum_square_loop_ctrl.sv
// Bench for accum_square_loop_ctrl: a behavioural modular multiplier plus a
// plain-arithmetic reference for x0^(2^T) mod N.
module tb_accum_square_loop_ctrl;

    localparam int BITS  = 382;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n;

    accum_square_loop_ctrl_if #(.BITS(BITS), .CNT_W(CNT_W)) bus ();

    accum_square_loop_ctrl #(.BITS(BITS), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    longint unsigned modulus     = 7;
    int              mul_lat     = 5;
    int              mul_rdy_pct = 100;
    int              mul_val_pct = 100;
    bit              force_stall = 0;
    bit              mul_abort   = 0;
    longint unsigned ops_q[$];

    function automatic longint unsigned ref_pow(input longint unsigned x0, input int t,
                                                input longint unsigned m);
        longint unsigned r = x0;
        for (int k = 0; k < t; k++) r = (r * r) % m;
        return r;
    endfunction

    // Multiplier model: accepts one operand pair, returns a*a mod N after
    // mul_lat idle cycles, and holds its result valid until taken.
    initial begin : mul_model
        bit busy = 0, op_hs = 0, res_hs = 0;
        int cnt = 0;
        longint unsigned res = 0, a;
        bus.i_mul_rdy = 1'b0;
        bus.i_mul_val = 1'b0;
        bus.i_mul_dat = '0;
        forever begin
            @(negedge clk);
            if (mul_abort) begin
                busy = 0; op_hs = 0; res_hs = 0; bus.i_mul_val = 1'b0;
            end
            if (res_hs) begin
                bus.i_mul_val = 1'b0; busy = 0; res_hs = 0;
            end
            if (op_hs) begin
                busy = 1; cnt = mul_lat; op_hs = 0;
            end else if (busy && cnt > 0) begin
                cnt--;
            end
            if (busy && bus.o_mul_val) begin
                vectors++; miscompares++;
                $display("FAIL outstanding: o_mul_val=1 while an operation is pending, required 0");
            end
            bus.i_mul_rdy = !busy && !force_stall && ($urandom_range(0, 99) < mul_rdy_pct);
            if (bus.o_mul_val && bus.i_mul_rdy) begin
                a = bus.o_mul_dat_a[63:0];
                vectors++;
                if (bus.o_mul_dat_b !== bus.o_mul_dat_a) begin
                    miscompares++;
                    $display("FAIL operand_pair: b=%0h, required a=%0h", bus.o_mul_dat_b[63:0], a);
                end
                ops_q.push_back(a);
                res   = (a * a) % modulus;
                op_hs = 1;
            end
            if (busy && cnt == 0 && !bus.i_mul_val && $urandom_range(0, 99) < mul_val_pct) begin
                bus.i_mul_val = 1'b1;
                bus.i_mul_dat = BITS'(res);
            end
            if (bus.i_mul_val && bus.o_mul_rdy) res_hs = 1;
        end
    end

    task automatic start_job(input longint unsigned x0, input int t, output bit ok);
        int n = 0;
        ok = 0;
        while (!bus.o_rdy && n < 5000) begin
            @(negedge clk); n++;
        end
        vectors++;
        if (!bus.o_rdy) begin
            miscompares++;
            $display("FAIL start_timeout: o_rdy=%0b, required 1", bus.o_rdy);
            return;
        end
        ops_q.delete();
        bus.i_val = 1'b1;
        bus.i_dat = BITS'(x0);
        bus.i_t   = CNT_W'(t);
        @(negedge clk);
        bus.i_val = 1'b0;
        bus.i_dat = BITS'({$urandom, $urandom});
        bus.i_t   = CNT_W'($urandom);
        ok = 1;
    endtask

    // Called one cycle after the job handshake; cyc counts cycles since it.
    task automatic wait_done(input int out_pct, output logic [BITS-1:0] dat,
                             output logic [CNT_W-1:0] iter, output int lat_cyc);
        int cyc = 1;
        bit stalled = 0, done = 0;
        logic [BITS-1:0] pdat = '0;
        lat_cyc = -1; dat = '0; iter = '0;
        while (!done && cyc < 20000) begin
            if (stalled) begin
                vectors++;
                if (bus.o_val !== 1'b1 || bus.o_dat !== pdat) begin
                    miscompares++;
                    $display("FAIL done_hold: o_val=%0b o_dat=%0h, required 1 %0h",
                             bus.o_val, bus.o_dat[63:0], pdat[63:0]);
                end
            end
            if (bus.o_val) begin
                if (lat_cyc < 0) lat_cyc = cyc;
                if ($urandom_range(0, 99) < out_pct) begin
                    bus.i_rdy = 1'b1; dat = bus.o_dat; iter = bus.o_iter; done = 1;
                end else begin
                    bus.i_rdy = 1'b0; stalled = 1; pdat = bus.o_dat;
                end
            end
            @(negedge clk); cyc++;
        end
        bus.i_rdy = 1'b0;
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout: o_val never accepted after %0d cycles, required completion", cyc);
        end
    endtask

    task automatic check_job(input string name, input logic [BITS-1:0] dat,
                             input logic [CNT_W-1:0] iter, input longint unsigned x0,
                             input int t);
        longint unsigned exp = ref_pow(x0, t, modulus);
        vectors++;
        if (dat !== BITS'(exp)) begin
            miscompares++;
            $display("FAIL %s_dat: got %0h, required %0h (x0=%0h T=%0d N=%0h)",
                     name, dat[63:0], exp, x0, t, modulus);
        end
        vectors++;
        if (iter !== CNT_W'(t)) begin
            miscompares++;
            $display("FAIL %s_iter: got %0d, required %0d", name, iter, t);
        end
        vectors++;
        if (ops_q.size() != t) begin
            miscompares++;
            $display("FAIL %s_ops: got %0d operand handshakes, required %0d", name, ops_q.size(), t);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.o_rdy !== 1'b1 || bus.o_val !== 1'b0 || bus.o_mul_val !== 1'b0 || bus.o_mul_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: rdy/val/mul_val/mul_rdy=%0b%0b%0b%0b, required 1000",
                     bus.o_rdy, bus.o_val, bus.o_mul_val, bus.o_mul_rdy);
        end
        vectors++;
        if (bus.o_dat !== '0 || bus.o_iter !== '0 || bus.o_mul_dat_a !== '0 || bus.o_mul_dat_b !== '0) begin
            miscompares++;
            $display("FAIL reset_data: o_dat=%0h o_iter=%0d a=%0h b=%0h, required all 0",
                     bus.o_dat[63:0], bus.o_iter, bus.o_mul_dat_a[63:0], bus.o_mul_dat_b[63:0]);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_known();
        logic [BITS-1:0] dat; logic [CNT_W-1:0] iter; int lat; bit ok;
        longint unsigned exp_ops[3];
        exp_ops[0] = 3; exp_ops[1] = 2; exp_ops[2] = 4;
        modulus = 7; mul_lat = 5; mul_rdy_pct = 100; mul_val_pct = 100;
        start_job(3, 3, ok);
        wait_done(100, dat, iter, lat);
        check_job("known", dat, iter, 3, 3);
        vectors++;
        if (dat !== BITS'(2)) begin
            miscompares++;
            $display("FAIL known_const: o_dat=%0h, required 2", dat[63:0]);
        end
        vectors++;
        if (lat != 3 * (5 + 2) + 1) begin
            miscompares++;
            $display("FAIL known_latency: o_val after %0d cycles, required %0d", lat, 3 * (5 + 2) + 1);
        end
        for (int k = 0; k < 3 && k < ops_q.size(); k++) begin
            vectors++;
            if (ops_q[k] !== exp_ops[k]) begin
                miscompares++;
                $display("FAIL known_op%0d: got %0d, required %0d", k, ops_q[k], exp_ops[k]);
            end
        end
    endtask

    task automatic test_t_zero();
        logic [BITS-1:0] dat; logic [CNT_W-1:0] iter; int lat; bit ok;
        start_job(64'h55, 0, ok);
        wait_done(100, dat, iter, lat);
        check_job("tzero", dat, iter, 64'h55, 0);
        vectors++;
        if (lat != 1) begin
            miscompares++;
            $display("FAIL tzero_latency: o_val after %0d cycles, required 1", lat);
        end
    endtask

    task automatic test_issue_stall();
        logic [BITS-1:0] dat; logic [CNT_W-1:0] iter; int lat; bit ok;
        force_stall = 1;
        start_job(5, 1, ok);
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (bus.o_mul_val !== 1'b1 || bus.o_mul_dat_a !== BITS'(5) || bus.o_mul_dat_b !== BITS'(5) ||
                bus.o_mul_rdy !== 1'b0 || bus.o_val !== 1'b0) begin
                miscompares++;
                $display("FAIL issue_hold%0d: mul_val=%0b a=%0h b=%0h mul_rdy=%0b o_val=%0b, required 1 5 5 0 0",
                         k, bus.o_mul_val, bus.o_mul_dat_a[63:0], bus.o_mul_dat_b[63:0],
                         bus.o_mul_rdy, bus.o_val);
            end
            @(negedge clk);
        end
        force_stall = 0;
        wait_done(100, dat, iter, lat);
        check_job("issue_stall", dat, iter, 5, 1);
    endtask

    task automatic test_done_stall();
        logic [BITS-1:0] dat, d0; logic [CNT_W-1:0] iter; int lat, n; bit ok;
        start_job(2, 2, ok);
        n = 0;
        while (!bus.o_val && n < 1000) begin
            @(negedge clk); n++;
        end
        d0 = bus.o_dat;
        vectors++;
        if (d0 !== BITS'(ref_pow(2, 2, modulus))) begin
            miscompares++;
            $display("FAIL stall_dat: o_dat=%0h, required %0h", d0[63:0], ref_pow(2, 2, modulus));
        end
        bus.i_val = 1'b1; bus.i_dat = BITS'(3); bus.i_t = CNT_W'(1);
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (bus.o_val !== 1'b1 || bus.o_dat !== d0 || bus.o_rdy !== 1'b0 || bus.o_iter !== CNT_W'(2)) begin
                miscompares++;
                $display("FAIL done_stall%0d: val=%0b dat=%0h rdy=%0b iter=%0d, required 1 %0h 0 2",
                         k, bus.o_val, bus.o_dat[63:0], bus.o_rdy, bus.o_iter, d0[63:0]);
            end
            @(negedge clk);
        end
        bus.i_rdy = 1'b1;
        @(negedge clk);
        bus.i_rdy = 1'b0;
        vectors++;
        if (bus.o_val !== 1'b0 || bus.o_rdy !== 1'b1 || bus.o_iter !== CNT_W'(2)) begin
            miscompares++;
            $display("FAIL done_release: val=%0b rdy=%0b iter=%0d, required 0 1 2",
                     bus.o_val, bus.o_rdy, bus.o_iter);
        end
        ops_q.delete();
        @(negedge clk);
        bus.i_val = 1'b0;
        vectors++;
        if (bus.o_rdy !== 1'b0 || bus.o_mul_val !== 1'b1 || bus.o_mul_dat_a !== BITS'(3) || bus.o_iter !== '0) begin
            miscompares++;
            $display("FAIL next_accept: rdy=%0b mul_val=%0b a=%0h iter=%0d, required 0 1 3 0",
                     bus.o_rdy, bus.o_mul_val, bus.o_mul_dat_a[63:0], bus.o_iter);
        end
        wait_done(100, dat, iter, lat);
        check_job("after_stall", dat, iter, 3, 1);
    endtask

    task automatic test_reset_in_wait();
        logic [BITS-1:0] dat; logic [CNT_W-1:0] iter; int lat, n; bit ok;
        modulus = 7; mul_lat = 20;
        start_job(3, 2, ok);
        n = 0;
        while (!bus.o_mul_rdy && n < 100) begin
            @(negedge clk); n++;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.o_rdy !== 1'b1 || bus.o_val !== 1'b0 || bus.o_mul_val !== 1'b0 || bus.o_mul_rdy !== 1'b0 ||
            bus.o_dat !== '0 || bus.o_iter !== '0 || bus.o_mul_dat_a !== '0) begin
            miscompares++;
            $display("FAIL wait_reset: rdy=%0b val=%0b mval=%0b mrdy=%0b dat=%0h iter=%0d, required 1 0 0 0 0 0",
                     bus.o_rdy, bus.o_val, bus.o_mul_val, bus.o_mul_rdy, bus.o_dat[63:0], bus.o_iter);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!bus.i_mul_val && n < 100) begin
            @(negedge clk); n++;
        end
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (bus.o_rdy !== 1'b1 || bus.o_val !== 1'b0 || bus.o_iter !== '0 || bus.o_mul_val !== 1'b0 ||
                bus.o_dat !== '0) begin
                miscompares++;
                $display("FAIL stale_result: rdy=%0b val=%0b iter=%0d mval=%0b dat=%0h, required 1 0 0 0 0",
                         bus.o_rdy, bus.o_val, bus.o_iter, bus.o_mul_val, bus.o_dat[63:0]);
            end
        end
        mul_abort = 1;
        @(negedge clk);
        mul_abort = 0;
        mul_lat = 3;
        start_job(5, 3, ok);
        wait_done(100, dat, iter, lat);
        check_job("post_reset", dat, iter, 5, 3);
    endtask

    task automatic test_max_t();
        logic [BITS-1:0] dat; logic [CNT_W-1:0] iter; int lat; bit ok;
        longint unsigned x0;
        modulus = longint'($urandom_range(1000, 32'h7fff_ffff)) | 1;
        x0 = longint'($urandom_range(2, 999));
        mul_lat = 0; mul_rdy_pct = 100; mul_val_pct = 100;
        start_job(x0, (1 << CNT_W) - 1, ok);
        wait_done(100, dat, iter, lat);
        check_job("max_t", dat, iter, x0, (1 << CNT_W) - 1);
    endtask

    task automatic test_back_to_back();
        logic [BITS-1:0] dat; logic [CNT_W-1:0] iter; int lat, t; bit ok;
        longint unsigned x0;
        mul_rdy_pct = 60; mul_val_pct = 60;
        for (int j = 0; j < 30; j++) begin
            modulus = longint'($urandom_range(3, 32'h7fff_ffff)) | 1;
            x0      = longint'($urandom_range(0, 32'h7fff_ffff)) % modulus;
            t       = $urandom_range(0, 12);
            mul_lat = $urandom_range(0, 4);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start_job(x0, t, ok);
            if (ok) begin
                wait_done(50, dat, iter, lat);
                check_job("b2b", dat, iter, x0, t);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.i_val = 1'b0;
        bus.i_dat = '0;
        bus.i_t   = '0;
        bus.i_rdy = 1'b0;
        test_reset();
        test_known();
        test_t_zero();
        test_issue_stall();
        test_done_stall();
        test_reset_in_wait();
        test_max_t();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
